// File: rtl/spi_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_engine
//  Description : SPI transmit serialiser. A DATA_W-bit shift register fed
//                by a FIFO_DEPTH-entry write FIFO. Bits move on the external
//                `sample` strobe, and queued words stream back-to-back with
//                no idle bit between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_engine #(
  parameter int   DATA_W     = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_LVL   = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        lsbf,
  input  logic                        sample,
  input  logic                        flush_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic                        sdo,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_W);

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  // Shifter state
  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              lsbf_q;

  logic head_avail;
  logic last_sample;
  logic push;
  logic pop;

  // A new frame may start only while enabled and the FIFO holds a word.
  assign head_avail  = en && (level != '0);
  assign last_sample = (state == ST_SHIFT) && sample && (bit_cnt == '0);

  // From IDLE a flush does not block the load; a back-to-back reload does
  // honour the flush so no flushed word ever reaches the line.
  assign pop  = ((state == ST_IDLE) && head_avail) ||
                (last_sample && head_avail && !flush_i);
  assign push = valid_i && ready_o && !flush_i;

  // Full is decided on the registered level only; a same-cycle pop does not
  // open a slot early.
  assign ready_o      = (level != FULL_LVL);
  assign level_o      = level;
  assign busy_o       = (state == ST_SHIFT);
  assign frame_done_o = last_sample;

  // Output end of the shifter is chosen by the bit order latched at load.
  assign sdo = (state == ST_SHIFT) ? (lsbf_q ? shreg[0] : shreg[DATA_W-1])
                                   : IDLE_LVL;

  // FIFO write port; storage needs no reset since level guards every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointers and occupancy; flush clears them, both may move in one cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Frame FSM: load from FIFO, shift on each strobe, reload back-to-back.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      lsbf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= LAST_BIT;
            lsbf_q  <= lsbf;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sample) begin
            if (bit_cnt != '0) begin
              shreg   <= lsbf_q ? (shreg >> 1) : (shreg << 1);
              bit_cnt <= bit_cnt - CNT_ONE;
            end else if (pop) begin
              shreg   <= mem[rd_ptr];
              bit_cnt <= LAST_BIT;
              lsbf_q  <= lsbf;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_tx_engine.md
# spi_tx_engine

Parametrised SPI serialiser: a DATA_W-bit transmit shifter fronted by a FIFO_DEPTH-entry write FIFO. It drives the SPI data-out line (sdo) on externally generated shift strobes and streams queued words back-to-back with no idle bit between frames. It sits between the APB register front-end (valid/ready word push) and the SPI clock generator (which produces `sample`).

## Interface

Parameters:
- DATA_W, 8: frame width in bits; legal values are 2 and above.
- FIFO_DEPTH, 4: FIFO entries; must be a power of 2, 2 or more.
- IDLE_LVL, 1'b0: level driven on sdo when no frame is active.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  transmit enable; gates the start of new frames only.
- lsbf  input  1  1 = LSB first, 0 = MSB first; latched at each frame load.
- sample  input  1  one-cycle shift strobe from the SPI clock generator.
- flush_i  input  1  synchronous FIFO clear.
- data_i  input  DATA_W  word to queue.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  FIFO not full; a push occurs when valid_i && ready_o.
- sdo  output  1  serial data out.
- busy_o  output  1  a frame is in the shifter (state SHIFT).
- frame_done_o  output  1  one-cycle pulse on the last bit's sample.
- level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, range 0..FIFO_DEPTH.

## Operation

- FIFO:
  - Circular buffer with $clog2(FIFO_DEPTH)-bit read and write pointers that wrap modulo FIFO_DEPTH, plus a level counter.
  - ready_o = (level_o != FIFO_DEPTH); it is not combinationally relieved by a same-cycle pop.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- flush_i:
  - Zeroes the pointers and level next cycle.
  - A push in the same cycle is dropped.
  - A pop in the same cycle still loads the shifter.
  - Does not abort the frame in the shifter.
- FSM states: IDLE, SHIFT.
  - IDLE: if en && level_o != 0, pop the head word into the shift register, set bit_cnt = DATA_W-1, latch lsbf, go to SHIFT.
  - SHIFT, on sample with bit_cnt != 0: shift one position toward the output end and decrement bit_cnt.
  - SHIFT, on sample with bit_cnt == 0: pulse frame_done_o. Then:
    - if en && level_o != 0 (and no flush this cycle), pop and reload in the same cycle and stay in SHIFT (back-to-back);
    - otherwise go to IDLE.
  - SHIFT with no sample: hold.
- sdo:
  - In SHIFT: sdo = shreg[0] if the latched lsbf is 1, else shreg[DATA_W-1].
  - In IDLE: sdo = IDLE_LVL.
  - sdo is driven registered-state-derived (no combinational path from inputs).
- en deasserted mid-frame: the current frame completes all DATA_W bits; no further loads occur.
- lsbf changed mid-frame: no effect until the next load.
- busy_o = (state == SHIFT).

## Timing

- Reset values: state IDLE, sdo = IDLE_LVL, ready_o = 1, busy_o = 0, frame_done_o = 0, level_o = 0, pointers 0, shift register 0.
- Reset mid-frame discards the frame and the FIFO contents immediately (asynchronous).
- Push-to-first-bit latency, empty FIFO, IDLE, en = 1:
  - push accepted at edge N;
  - level_o = 1 after edge N;
  - load at edge N+1;
  - first bit valid on sdo and busy_o = 1 after edge N+1.
- A frame occupies exactly DATA_W sample strobes.
- The bit on sdo changes only on the edge at which sample is high.
- Back-to-back frames: the first bit of word k+1 is on sdo on the cycle after the edge carrying word k's last sample. There is no IDLE cycle between frames.
- sample held high for consecutive cycles shifts one bit per cycle (no strobe-width requirement).
- sample in IDLE is ignored.

## Test plan

- Single word, DATA_W = 8, lsbf = 0, push 8'hA5, sample every 4th cycle:
  - sdo sequence must be 1,0,1,0,0,1,0,1;
  - frame_done_o pulses once on the 8th sample;
  - sdo returns to IDLE_LVL the next cycle.
- Same word with lsbf = 1: sdo sequence must be 1,0,1,0,0,1,0,1 reversed (i.e. 8'hA5 LSB first: 1,0,1,0,0,1,0,1 read from bit 0 upward).
- Fill the FIFO while en = 0:
  - after pushing 4 words, ready_o = 0 and a 5th valid_i is not accepted;
  - raise en: all 4 words stream with busy_o continuously 1 and exactly 4 frame_done_o pulses, then level_o = 0.
- Push 8'hFF, then drop en after the 3rd sample with 2 words queued:
  - the frame completes all 8 bits;
  - the state returns to IDLE with level_o = 2.
- Assert flush_i mid-frame with 3 words queued:
  - the current frame completes;
  - level_o = 0 next cycle;
  - no further frames start.
- Assert rst_n low during the 5th bit:
  - sdo = IDLE_LVL, busy_o = 0, level_o = 0 and ready_o = 1 immediately;
  - no frame_done_o pulse occurs.
